// File: rtl/cpu_id_hz.sv
// PLP instruction decode stage: register file with WB bypass,
// valid/ready handshake, load-use interlock and redirect targets.
package cpu_id_hz_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;

  typedef enum logic {
    S_RUN,
    S_STALL
  } state_t;

endpackage

module cpu_id_hz
  import cpu_id_hz_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_inst,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            wb_rfw,
  input  logic [4:0]      wb_rf_waddr,
  input  logic [XLEN-1:0] wb_rf_wdata,
  output logic            p_valid,
  output logic [XLEN-1:0] p_rfa,
  output logic [XLEN-1:0] p_rfb,
  output logic [XLEN-1:0] p_rfbse,
  output logic [4:0]      p_shamt,
  output logic [5:0]      p_func,
  output logic [4:0]      p_rf_waddr,
  output logic [31:0]     p_jalra,
  output logic            p_c_rfw,
  output logic [1:0]      p_c_wbsource,
  output logic            p_c_drw,
  output logic [5:0]      p_c_alucontrol,
  output logic            c_b,
  output logic            c_j,
  output logic [31:0]     baddr,
  output logic [31:0]     jaddr
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rfa;
    logic [XLEN-1:0] rfb;
    logic [XLEN-1:0] rfbse;
    logic [4:0]      shamt;
    logic [5:0]      func;
    logic [4:0]      waddr;
    logic [31:0]     jalra;
    logic            rfw;
    logic [1:0]      wbsource;
    logic            drw;
    logic [5:0]      alucontrol;
  } id_ex_t;

  logic [XLEN-1:0] rf [NREG];

  id_ex_t p;
  id_ex_t dec;
  state_t state;
  state_t state_nxt;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [15:0] imm;

  assign op    = if_inst[31:26];
  assign rs    = if_inst[25:21];
  assign rt    = if_inst[20:16];
  assign rd    = if_inst[15:11];
  assign shamt = if_inst[10:6];
  assign func  = if_inst[5:0];
  assign imm   = if_inst[15:0];

  logic wb_ok;
  logic rs_ok;
  logic rt_ok;
  logic [XLEN-1:0] rs_v;
  logic [XLEN-1:0] rt_v;

  assign wb_ok = wb_rfw && (wb_rf_waddr != 5'd0)
              && ({1'b0, wb_rf_waddr} < 6'(NREG));
  assign rs_ok = (rs != 5'd0) && ({1'b0, rs} < 6'(NREG));
  assign rt_ok = (rt != 5'd0) && ({1'b0, rt} < 6'(NREG));

  // Write-first: a same-cycle WB write wins over the stored value
  always_comb begin
    rs_v = '0;
    rt_v = '0;
    if (rs_ok)
      rs_v = (wb_ok && wb_rf_waddr == rs) ? wb_rf_wdata
                                          : rf[rs[AW-1:0]];
    if (rt_ok)
      rt_v = (wb_ok && wb_rf_waddr == rt) ? wb_rf_wdata
                                          : rf[rt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wb_ok) begin
      rf[wb_rf_waddr[AW-1:0]] <= wb_rf_wdata;
    end
  end

  logic is_r;
  logic is_j;
  logic is_jal;
  logic is_beq;
  logic is_bne;
  logic is_lw;
  logic is_sw;
  logic is_zx;
  logic is_jr;
  logic is_jalr;
  logic reads_rt;

  assign is_r     = (op == OP_R);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_zx    = (op == OP_ANDI) || (op == OP_ORI);
  assign is_jr    = is_r && (func == F_JR);
  assign is_jalr  = is_r && (func == F_JALR);
  assign reads_rt = is_r | is_beq | is_bne | is_sw;

  logic [XLEN-1:0] imm_x;
  logic [1:0]      wbs;
  logic [4:0]      waddr;

  assign imm_x = is_zx ? {{(XLEN-16){1'b0}}, imm}
                       : {{(XLEN-16){imm[15]}}, imm};

  always_comb begin
    wbs = 2'd0;
    unique case (1'b1)
      is_lw:              wbs = 2'd1;
      (is_jal | is_jalr): wbs = 2'd2;
      default:            wbs = 2'd0;
    endcase
  end

  always_comb begin
    waddr = rt;
    unique case (1'b1)
      is_r:    waddr = rd;
      is_jal:  waddr = 5'd31;
      default: waddr = rt;
    endcase
  end

  always_comb begin
    dec            = '0;
    dec.valid      = 1'b1;
    dec.rfa        = rs_v;
    dec.rfb        = rt_v;
    dec.rfbse      = is_r ? rt_v : imm_x;
    dec.shamt      = shamt;
    dec.func       = func;
    dec.waddr      = waddr;
    dec.jalra      = if_pc + 32'd8;
    dec.rfw        = ~(is_beq | is_bne | is_sw | is_j);
    dec.wbsource   = wbs;
    dec.drw        = is_sw;
    dec.alucontrol = op;
  end

  logic [31:0] pc4;
  logic        taken;
  logic        jump;

  assign pc4   = if_pc + 32'd4;
  assign baddr = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign jaddr = (is_jr | is_jalr) ? rs_v[31:0]
                                   : {pc4[31:28], if_inst[25:0], 2'b00};
  assign taken = (is_beq & (rs_v == rt_v)) | (is_bne & (rs_v != rt_v));
  assign jump  = is_j | is_jal | is_jr | is_jalr;

  logic hz;
  logic accept;

  // A load in EX whose result this instruction needs forces one bubble
  assign hz = (HAZARD_EN != 0) && p.valid && (p.wbsource == 2'd1)
           && (p.waddr != 5'd0)
           && ((p.waddr == rs) || ((p.waddr == rt) && reads_rt));

  assign id_ready = rst & ex_ready
                  & ~((state == S_RUN) & hz & if_valid);
  assign accept   = if_valid & id_ready;
  assign c_b      = accept & taken;
  assign c_j      = accept & jump;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN:   if (if_valid & hz & ex_ready) state_nxt = S_STALL;
      S_STALL: if (ex_ready) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          p <= '0;
    else if (ex_ready) p <= accept ? dec : '0;
  end

  assign p_valid        = p.valid;
  assign p_rfa          = p.rfa;
  assign p_rfb          = p.rfb;
  assign p_rfbse        = p.rfbse;
  assign p_shamt        = p.shamt;
  assign p_func         = p.func;
  assign p_rf_waddr     = p.waddr;
  assign p_jalra        = p.jalra;
  assign p_c_rfw        = p.rfw;
  assign p_c_wbsource   = p.wbsource;
  assign p_c_drw        = p.drw;
  assign p_c_alucontrol = p.alucontrol;

endmodule

// File: tb/tb_cpu_id_hz.sv
// Directed bench for cpu_id_hz: scoreboard of issued bundles plus
// cycle checks on handshake, interlock, redirects and a NREG=16 copy.
module tb_cpu_id_hz;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        ex_ready;
  logic        wb_rfw;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;

  logic        id_ready, p_valid, p_c_rfw, p_c_drw, c_b, c_j;
  logic [31:0] p_rfa, p_rfb, p_rfbse, p_jalra, baddr, jaddr;
  logic [4:0]  p_shamt, p_rf_waddr;
  logic [5:0]  p_func, p_c_alucontrol;
  logic [1:0]  p_c_wbsource;

  logic        id_ready_2, p_valid_2, p_c_rfw_2, p_c_drw_2, c_b_2, c_j_2;
  logic [31:0] p_rfa_2, p_rfb_2, p_rfbse_2, p_jalra_2, baddr_2, jaddr_2;
  logic [4:0]  p_shamt_2, p_rf_waddr_2;
  logic [5:0]  p_func_2, p_c_alucontrol_2;
  logic [1:0]  p_c_wbsource_2;

  always #5 clk = ~clk;

  cpu_id_hz dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_ready(id_ready), .ex_ready(ex_ready),
    .wb_rfw(wb_rfw), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata),
    .p_valid(p_valid), .p_rfa(p_rfa), .p_rfb(p_rfb),
    .p_rfbse(p_rfbse), .p_shamt(p_shamt), .p_func(p_func),
    .p_rf_waddr(p_rf_waddr), .p_jalra(p_jalra),
    .p_c_rfw(p_c_rfw), .p_c_wbsource(p_c_wbsource),
    .p_c_drw(p_c_drw), .p_c_alucontrol(p_c_alucontrol),
    .c_b(c_b), .c_j(c_j), .baddr(baddr), .jaddr(jaddr)
  );

  cpu_id_hz #(.NREG(16), .HAZARD_EN(0)) dut2 (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_ready(id_ready_2), .ex_ready(ex_ready),
    .wb_rfw(wb_rfw), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata),
    .p_valid(p_valid_2), .p_rfa(p_rfa_2), .p_rfb(p_rfb_2),
    .p_rfbse(p_rfbse_2), .p_shamt(p_shamt_2), .p_func(p_func_2),
    .p_rf_waddr(p_rf_waddr_2), .p_jalra(p_jalra_2),
    .p_c_rfw(p_c_rfw_2), .p_c_wbsource(p_c_wbsource_2),
    .p_c_drw(p_c_drw_2), .p_c_alucontrol(p_c_alucontrol_2),
    .c_b(c_b_2), .c_j(c_j_2), .baddr(baddr_2), .jaddr(jaddr_2)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] rfa;
    logic [31:0] rfbse;
    logic [31:0] jalra;
    logic        rfw;
    logic [1:0]  wbs;
    logic        drw;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rt_i(logic [4:0] rs, logic [4:0] rt,
                                       logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_i(logic [5:0] op, logic [4:0] rs,
                                       logic [4:0] rt, logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] jt_i(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  task automatic present(logic [31:0] pc, logic [31:0] inst,
                         logic [4:0] wa, logic [31:0] ra,
                         logic [31:0] rb, logic rfw,
                         logic [1:0] wbs, logic drw);
    exp_t e;
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    e.waddr  = wa;
    e.rfa    = ra;
    e.rfbse  = rb;
    e.jalra  = pc + 32'd8;
    e.rfw    = rfw;
    e.wbs    = wbs;
    e.drw    = drw;
    sb.push_back(e);
  endtask

  // One rising edge; a newly loaded valid bundle is matched to the queue
  task automatic cyc();
    logic adv;
    exp_t e;
    adv = ex_ready & rst;
    @(posedge clk);
    #1;
    if (adv && p_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", 64'(p_rf_waddr), 64'hdead);
      end else begin
        e = sb.pop_front();
        chk("sb_waddr", 64'(p_rf_waddr), 64'(e.waddr));
        chk("sb_rfa", 64'(p_rfa), 64'(e.rfa));
        chk("sb_rfbse", 64'(p_rfbse), 64'(e.rfbse));
        chk("sb_jalra", 64'(p_jalra), 64'(e.jalra));
        chk("sb_rfw", 64'(p_c_rfw), 64'(e.rfw));
        chk("sb_wbsource", 64'(p_c_wbsource), 64'(e.wbs));
        chk("sb_drw", 64'(p_c_drw), 64'(e.drw));
      end
    end
  endtask

  task automatic wb(logic [4:0] a, logic [31:0] d);
    wb_rfw      = 1'b1;
    wb_rf_waddr = a;
    wb_rf_wdata = d;
    cyc();
    wb_rfw      = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    ex_ready    = 1'b1;
    if_valid    = 1'b1;
    if_pc       = 32'h1000_0000;
    if_inst     = jt_i(6'h02, 26'h40);
    wb_rfw      = 1'b0;
    wb_rf_waddr = 5'd0;
    wb_rf_wdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_id_ready", 64'(id_ready), 64'd0);
    chk("rst_c_j", 64'(c_j), 64'd0);
    chk("rst_p_valid", 64'(p_valid), 64'd0);
    chk("rst_p_waddr", 64'(p_rf_waddr), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    if_valid = 1'b0;
    cyc();

    wb(5'd1, 32'h11);
    wb(5'd2, 32'h100);

    // same-cycle WB bypass
    wb_rfw      = 1'b1;
    wb_rf_waddr = 5'd5;
    wb_rf_wdata = 32'h1234;
    present(32'h0, rt_i(5'd5, 5'd0, 5'd6, 6'h20),
            5'd6, 32'h1234, 32'h0, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    chk("byp_id_ready", 64'(id_ready), 64'd1);
    cyc();
    wb_rfw = 1'b0;
    chk("n16_byp_rfa", 64'(p_rfa_2), 64'h1234);

    // load-use, with a WB write of the loaded register in the stall cycle
    present(32'h4, it_i(6'h23, 5'd2, 5'd4, 16'h0),
            5'd4, 32'h100, 32'h0, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    chk("lw_id_ready", 64'(id_ready), 64'd1);
    cyc();
    present(32'h8, rt_i(5'd4, 5'd1, 5'd3, 6'h21),
            5'd3, 32'habcd, 32'h11, 1'b1, 2'd0, 1'b0);
    wb_rfw      = 1'b1;
    wb_rf_waddr = 5'd4;
    wb_rf_wdata = 32'habcd;
    @(negedge clk);
    chk("lu_stall_ready", 64'(id_ready), 64'd0);
    chk("lu_stall_c_j", 64'(c_j), 64'd0);
    chk("nohz_ready", 64'(id_ready_2), 64'd1);
    cyc();
    wb_rfw = 1'b0;
    chk("lu_bubble_valid", 64'(p_valid), 64'd0);
    chk("lu_bubble_rfw", 64'(p_c_rfw), 64'd0);
    chk("lu_bubble_drw", 64'(p_c_drw), 64'd0);
    chk("nohz_valid", 64'(p_valid_2), 64'd1);
    chk("nohz_waddr", 64'(p_rf_waddr_2), 64'd3);
    chk("nohz_rfa", 64'(p_rfa_2), 64'habcd);
    @(negedge clk);
    chk("lu_resume_ready", 64'(id_ready), 64'd1);
    cyc();

    // backpressure with a taken branch presented
    present(32'h100, it_i(6'h04, 5'd1, 5'd1, 16'hffff),
            5'd1, 32'h11, 32'hffff_ffff, 1'b0, 2'd0, 1'b0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_id_ready", 64'(id_ready), 64'd0);
      chk("bp_c_b", 64'(c_b), 64'd0);
      cyc();
      chk("bp_p_valid", 64'(p_valid), 64'd1);
      chk("bp_p_waddr", 64'(p_rf_waddr), 64'd3);
      chk("bp_p_rfa", 64'(p_rfa), 64'habcd);
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("beq_c_b", 64'(c_b), 64'd1);
    chk("beq_baddr", 64'(baddr), 64'h100);
    cyc();

    present(32'h1000_0000, jt_i(6'h02, 26'h40),
            5'd0, 32'h0, 32'h40, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("j_c_j", 64'(c_j), 64'd1);
    chk("j_c_b", 64'(c_b), 64'd0);
    chk("j_jaddr", 64'(jaddr), 64'h1000_0100);
    cyc();

    present(32'h200, jt_i(6'h03, 26'h80),
            5'd31, 32'h0, 32'h80, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    chk("jal_c_j", 64'(c_j), 64'd1);
    chk("jal_jaddr", 64'(jaddr), 64'h200);
    cyc();

    present(32'h300, rt_i(5'd2, 5'd0, 5'd0, 6'h08),
            5'd0, 32'h100, 32'h0, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    chk("jr_c_j", 64'(c_j), 64'd1);
    chk("jr_jaddr", 64'(jaddr), 64'h100);
    cyc();

    present(32'h304, it_i(6'h2b, 5'd2, 5'd1, 16'h4),
            5'd1, 32'h100, 32'h4, 1'b0, 2'd0, 1'b1);
    cyc();
    present(32'h308, it_i(6'h0c, 5'd1, 5'd8, 16'h8000),
            5'd8, 32'h11, 32'h0000_8000, 1'b1, 2'd0, 1'b0);
    cyc();
    chk("n16_andi_rfbse", 64'(p_rfbse_2), 64'h0000_8000);
    present(32'h30c, it_i(6'h08, 5'd0, 5'd9, 16'h8000),
            5'd9, 32'h0, 32'hffff_8000, 1'b1, 2'd0, 1'b0);
    cyc();

    present(32'h310, it_i(6'h05, 5'd1, 5'd1, 16'h5),
            5'd1, 32'h11, 32'h5, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("bne_nt_c_b", 64'(c_b), 64'd0);
    cyc();
    present(32'h314, it_i(6'h05, 5'd1, 5'd2, 16'h5),
            5'd2, 32'h11, 32'h5, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("bne_t_c_b", 64'(c_b), 64'd1);
    chk("bne_t_baddr", 64'(baddr), 64'h32c);
    cyc();

    // r20 exists only in the 32-entry file
    if_valid = 1'b0;
    wb(5'd20, 32'h7);
    present(32'h320, rt_i(5'd20, 5'd20, 5'd10, 6'h20),
            5'd10, 32'h7, 32'h7, 1'b1, 2'd0, 1'b0);
    cyc();
    chk("n16_r20_rfa", 64'(p_rfa_2), 64'd0);
    chk("n16_r20_rfb", 64'(p_rfb_2), 64'd0);

    // asynchronous reset pulse while a valid bundle is held
    if_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("arst_p_valid", 64'(p_valid), 64'd0);
    chk("arst_p_waddr", 64'(p_rf_waddr), 64'd0);
    chk("arst_p_rfa", 64'(p_rfa), 64'd0);
    chk("arst_p_jalra", 64'(p_jalra), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // registers cleared; then reset in the middle of a stall
    present(32'h400, it_i(6'h23, 5'd2, 5'd4, 16'h0),
            5'd4, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0);
    cyc();
    present(32'h404, rt_i(5'd4, 5'd1, 5'd3, 6'h21),
            5'd3, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    chk("rs_stall_ready", 64'(id_ready), 64'd0);
    cyc();
    chk("rs_bubble_valid", 64'(p_valid), 64'd0);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rs_mid_valid", 64'(p_valid), 64'd0);
    chk("rs_mid_ready", 64'(id_ready), 64'd0);
    if_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    present(32'h500, it_i(6'h23, 5'd0, 5'd4, 16'h0),
            5'd4, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0);
    cyc();
    present(32'h504, rt_i(5'd4, 5'd4, 5'd5, 6'h21),
            5'd5, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    chk("post_stall_ready", 64'(id_ready), 64'd0);
    cyc();
    @(negedge clk);
    chk("post_resume_ready", 64'(id_ready), 64'd1);
    cyc();
    if_valid = 1'b0;
    cyc();
    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_id_hz.md
Name: cpu_id_hz

Overview:
Parametrised next-generation instruction decode stage for the PLP pipeline. It sits between the IF stage and the EX stage. It decodes the same ISA opcode set and reads a configurable-size register file, with a write-first bypass from WB. The previous stage has none of the following, which this block adds:
- valid/ready pipeline handshake
- load-use interlock FSM
- correctly formed jump targets
- branch/jump redirect qualified by acceptance

Parameters:
XLEN, 32, datapath width; immediates are sign/zero-extended to XLEN; must be >= 32.
NREG, 32, number of architectural registers; power of 2, 8..32; register 0 is hardwired to zero.
HAZARD_EN, 1, 1 enables the load-use interlock; 0 removes it (software schedules the hazard).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
if_valid  in  1  IF presents a valid instruction
if_pc  in  32  PC of the presented instruction
if_inst  in  32  presented instruction
id_ready  out  1  ID accepts if_inst this cycle
ex_ready  in  1  EX can accept the p_* bundle
wb_rfw  in  1  WB register write enable
wb_rf_waddr  in  5  WB destination register
wb_rf_wdata  in  XLEN  WB write data
p_valid  out  1  p_* bundle holds a real instruction (0 = bubble)
p_rfa, p_rfb, p_rfbse  out  XLEN  rs value, rt value, B operand (se/ze imm or rt)
p_shamt  out  5  shift amount
p_func  out  6  function field
p_rf_waddr  out  5  destination register
p_jalra  out  32  if_pc+8
p_c_rfw  out  1  register write enable
p_c_wbsource  out  2  WB source select
p_c_drw  out  1  data memory write
p_c_alucontrol  out  6  opcode passed to ALU
c_b, c_j  out  1  branch taken / jump, combinational
baddr, jaddr  out  32  redirect targets, combinational

Behaviour:
- Reset (rst=0, asynchronous):
  - All p_* outputs, p_valid and every register file entry go to 0.
  - The FSM goes to RUN.
  - id_ready, c_b and c_j are 0 while rst=0.
- Register read:
  - Registers with index >= NREG and register 0 read as 0.
  - Writes to r0 or to an index >= NREG are ignored.
  - Write-first bypass: if wb_rfw=1, wb_rf_waddr!=0 and wb_rf_waddr equals rs or rt, the read returns wb_rf_wdata in the same cycle.
  - This bypass also feeds the c_b comparison and jr/jalr jaddr.
- Decode follows the PLP ISA:
  - c_rfw=0 for beq(04), bne(05), sw(2b), j(02).
  - wbsource=1 for lw(23); wbsource=2 for jal(03) and jalr(00/09); otherwise 0.
  - drw=1 for sw only.
  - andi/ori (0c/0d) zero-extend the immediate; all other opcodes sign-extend.
  - rfbse = rt value for opcode 00, extended immediate otherwise.
  - Destination register: rd for opcode 00, 31 for jal, rt otherwise.
- Targets:
  - baddr = if_pc + 4 + (sext(imm) << 2).
  - jaddr = rs value for jr/jalr; otherwise {pc4[31:28], inst[25:0], 2'b00}, where pc4 = if_pc+4.
- FSM has states RUN and STALL:
  - hz = HAZARD_EN & p_valid & (p_c_wbsource==1) & (p_rf_waddr!=0) & (p_rf_waddr==rs | (p_rf_waddr==rt & the current instruction reads rt)).
  - rt is read by opcode 00, beq, bne and sw.
  - RUN: if if_valid & hz & ex_ready, load a bubble (p_valid=0, p_c_rfw=0, p_c_drw=0) and go to STALL. id_ready=0 in this cycle.
  - STALL: id_ready follows ex_ready; go to RUN on the next ex_ready.
- Handshake:
  - id_ready = ex_ready & ~(state==RUN & hz & if_valid).
  - Accept = if_valid & id_ready. On accept, p_* loads the decoded values and p_valid=1.
  - If if_valid=0 and ex_ready=1, a bubble is loaded.
  - If ex_ready=0, every p_* register holds its value.
- c_b and c_j are asserted only on the accept cycle; otherwise 0. IF must not redirect on a stalled instruction.
- Simultaneous WB write and a stalled read: the bypass applies, and the stall still inserts exactly one bubble.
- Reset mid-stall: the FSM returns to RUN and the bubble is discarded.

Test Plan:
- Reset: pulse rst=0 mid-run → all p_* = 0, p_valid=0; every register reads 0 after release.
- Bypass: wb writes r5=0x1234 in the same cycle that `add r6,r5,r0` is presented → p_rfa=0x1234, p_rf_waddr=6.
- Load-use: `lw r4,0(r2)` then `addu r3,r4,r1` → id_ready=0 for 1 cycle, one bubble (p_valid=0), then addu issues with p_rf_waddr=3. With HAZARD_EN=0 → no bubble.
- Backpressure: ex_ready=0 for 3 cycles → p_* stable, id_ready=0, c_b=0 even when a taken beq is presented.
- Branch/jump: beq r1,r1,-1 at pc=0x100 → c_b=1, baddr=0x100. j 0x40 at pc=0x10000000 → jaddr=0x10000100. jal → p_rf_waddr=31, p_jalra=pc+8.
- NREG=16: write r20=7 → r20 reads 0. andi with imm 0x8000 → p_rfbse=0x00008000.
